// File: rtl/pinv_weight_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pinv_weight_gen: 2x2 Gram inverse times A^H -> 2 x MIC_NUM weight matrix    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pinv_weight_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 14,
    parameter int INV_FRAC   = 30,
    parameter int LATENCY    = 2,
    parameter int MIC_NUM    = 8,
    parameter int SOR_NUM    = 2,
    parameter int FREQ_NUM   = 257,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8:0]            freq_idx,
    input  logic [ACC_WIDTH-1:0]  g11_real,
    input  logic [ACC_WIDTH-1:0]  g22_real,
    input  logic [ACC_WIDTH-1:0]  g12_real,
    input  logic [ACC_WIDTH-1:0]  g12_imag,
    input  logic [ACC_WIDTH-1:0]  inv_det,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    input  logic [DATA_WIDTH-1:0] af_bram_rd_real,
    input  logic [DATA_WIDTH-1:0] af_bram_rd_imag,
    output logic                  result_bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [DATA_WIDTH-1:0] result_bram_wr_real,
    output logic [DATA_WIDTH-1:0] result_bram_wr_imag,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int c_G_FRAC = 28;
    localparam int c_GSH    = c_G_FRAC + INV_FRAC - FRAC_BITS;
    localparam int c_PW     = 2 * ACC_WIDTH;
    localparam int c_SW     = 2 * DATA_WIDTH + 2;
    localparam int c_MIC_W  = $clog2(MIC_NUM + 1);
    localparam int c_WC_W   = $clog2(LATENCY + 1);
    localparam logic signed [c_PW-1:0] c_SMAX = (c_PW'(1) <<< (DATA_WIDTH - 1)) - c_PW'(1);
    localparam logic signed [c_PW-1:0] c_SMIN = ~c_SMAX;
    localparam logic signed [c_SW-1:0] c_HALF = c_SW'(1) <<< (FRAC_BITS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_GINV, S_RD0, S_RD1, S_WAIT, S_CAP, S_WR0, S_WR1, S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [c_MIC_W-1:0]             mic_q, mic_d;
    logic [c_WC_W-1:0]              wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0]          rd_addr_q, rd_addr_d;
    logic                           err_q, err_d;
    logic [8:0]                     freq_q;
    logic signed [ACC_WIDTH-1:0]    g11_q, g22_q, g12r_q, g12i_q, inv_q;
    logic signed [DATA_WIDTH-1:0]   ginv_re_q [0:3];
    logic signed [DATA_WIDTH-1:0]   ginv_im_q [0:3];
    logic signed [DATA_WIDTH-1:0]   a_re_q [0:1];
    logic signed [DATA_WIDTH-1:0]   a_im_q [0:1];
    logic                           accept, cap0, cap1;

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [c_PW-1:0] x);
        if (x > c_SMAX)      sat = c_SMAX[DATA_WIDTH-1:0];
        else if (x < c_SMIN) sat = c_SMIN[DATA_WIDTH-1:0];
        else                 sat = x[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [c_MIC_W-1:0]   m,
                                                        input logic                 s);
        elem_addr = base + (s ? ADDR_WIDTH'(MIC_NUM) : '0) + ADDR_WIDTH'(m);
    endfunction

    logic [ADDR_WIDTH-1:0] w_base;
    assign w_base = ADDR_WIDTH'(freq_q) * ADDR_WIDTH'(MIC_NUM * SOR_NUM);

    // Full-precision products for the adjugate scaling
    logic signed [c_PW-1:0] p_g11, p_g22, p_12r, p_12i;
    assign p_g11 = c_PW'(inv_q) * c_PW'(g11_q);
    assign p_g22 = c_PW'(inv_q) * c_PW'(g22_q);
    assign p_12r = c_PW'(inv_q) * c_PW'(g12r_q);
    assign p_12i = c_PW'(inv_q) * c_PW'(g12i_q);

    // Ginv is stored row-major: index = 2*row + column
    logic                          row;
    logic signed [DATA_WIDTH-1:0]  gr0, gi0, gr1, gi1;
    logic signed [c_SW-1:0]        w_re, w_im, w_re_r, w_im_r;
    assign row = (state_q == S_WR1);
    assign gr0 = ginv_re_q[{row, 1'b0}];
    assign gi0 = ginv_im_q[{row, 1'b0}];
    assign gr1 = ginv_re_q[{row, 1'b1}];
    assign gi1 = ginv_im_q[{row, 1'b1}];

    assign w_re = c_SW'(gr0) * c_SW'(a_re_q[0]) + c_SW'(gi0) * c_SW'(a_im_q[0])
                + c_SW'(gr1) * c_SW'(a_re_q[1]) + c_SW'(gi1) * c_SW'(a_im_q[1]);
    assign w_im = c_SW'(gi0) * c_SW'(a_re_q[0]) - c_SW'(gr0) * c_SW'(a_im_q[0])
                + c_SW'(gi1) * c_SW'(a_re_q[1]) - c_SW'(gr1) * c_SW'(a_im_q[1]);
    assign w_re_r = (w_re + c_HALF) >>> FRAC_BITS;
    assign w_im_r = (w_im + c_HALF) >>> FRAC_BITS;

    always_comb begin
        state_d   = state_q;
        mic_d     = mic_q;
        wcnt_d    = wcnt_q;
        rd_addr_d = rd_addr_q;
        err_d     = 1'b0;
        accept    = 1'b0;
        cap0      = 1'b0;
        cap1      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (int'(freq_idx) < FREQ_NUM) begin
                        accept  = 1'b1;
                        state_d = S_GINV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_GINV: begin
                mic_d     = '0;
                rd_addr_d = elem_addr(w_base, '0, 1'b0);
                state_d   = S_RD0;
            end
            S_RD0: begin
                rd_addr_d = elem_addr(w_base, mic_q, 1'b1);
                state_d   = S_RD1;
            end
            S_RD1: begin
                if (LATENCY == 1) begin
                    cap0    = 1'b1;
                    state_d = S_CAP;
                end else begin
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (int'(wcnt_q) == LATENCY - 2) begin
                    cap0    = 1'b1;
                    state_d = S_CAP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_CAP: begin
                cap1    = 1'b1;
                state_d = S_WR0;
            end
            S_WR0: state_d = S_WR1;
            S_WR1: begin
                if (mic_q == c_MIC_W'(MIC_NUM - 1)) begin
                    state_d = S_DONE;
                end else begin
                    mic_d     = mic_q + 1'b1;
                    rd_addr_d = elem_addr(w_base, mic_q + 1'b1, 1'b0);
                    state_d   = S_RD0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mic_q     <= '0;
            wcnt_q    <= '0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
            freq_q    <= '0;
            g11_q     <= '0;
            g22_q     <= '0;
            g12r_q    <= '0;
            g12i_q    <= '0;
            inv_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                ginv_re_q[i] <= '0;
                ginv_im_q[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                a_re_q[i] <= '0;
                a_im_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mic_q     <= mic_d;
            wcnt_q    <= wcnt_d;
            rd_addr_q <= rd_addr_d;
            err_q     <= err_d;
            if (accept) begin
                freq_q <= freq_idx;
                g11_q  <= g11_real;
                g22_q  <= g22_real;
                g12r_q <= g12_real;
                g12i_q <= g12_imag;
                inv_q  <= inv_det;
            end
            if (state_q == S_GINV) begin
                ginv_re_q[0] <= sat(p_g22 >>> c_GSH);
                ginv_im_q[0] <= '0;
                ginv_re_q[1] <= sat((-p_12r) >>> c_GSH);
                ginv_im_q[1] <= sat((-p_12i) >>> c_GSH);
                ginv_re_q[2] <= sat((-p_12r) >>> c_GSH);
                ginv_im_q[2] <= sat(p_12i >>> c_GSH);
                ginv_re_q[3] <= sat(p_g11 >>> c_GSH);
                ginv_im_q[3] <= '0;
            end
            if (cap0) begin
                a_re_q[0] <= af_bram_rd_real;
                a_im_q[0] <= af_bram_rd_imag;
            end
            if (cap1) begin
                a_re_q[1] <= af_bram_rd_real;
                a_im_q[1] <= af_bram_rd_imag;
            end
        end
    end

    assign bram_rd_addr        = rd_addr_q;
    assign err                 = err_q;
    assign done                = (state_q == S_DONE);
    assign busy                = (state_q != S_IDLE);
    assign result_bram_wr_en   = (state_q == S_WR0) || (state_q == S_WR1);
    assign bram_wr_addr        = result_bram_wr_en ? elem_addr(w_base, mic_q, row) : '0;
    assign result_bram_wr_real = result_bram_wr_en ? sat(c_PW'(w_re_r)) : '0;
    assign result_bram_wr_imag = result_bram_wr_en ? sat(c_PW'(w_im_r)) : '0;

endmodule
`default_nettype wire

// File: tb/tb_pinv_weight_gen.sv
`default_nettype none
// Directed-vector bench for pinv_weight_gen with a latency-2 steering BRAM model.
module tb_pinv_weight_gen;

    localparam int L   = 2;
    localparam int MIC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  freq_idx = '0;
    logic [31:0] g11 = '0, g22 = '0, g12r = '0, g12i = '0, inv = '0;
    logic [12:0] bram_rd_addr, bram_wr_addr;
    logic [15:0] af_re, af_im, wr_re, wr_im;
    logic        wr_en, busy, done, err;

    always #5 clk = ~clk;

    pinv_weight_gen #(
        .DATA_WIDTH(16), .ACC_WIDTH(32), .FRAC_BITS(14), .INV_FRAC(30),
        .LATENCY(L), .MIC_NUM(MIC), .SOR_NUM(2), .FREQ_NUM(257), .ADDR_WIDTH(13)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .freq_idx(freq_idx),
        .g11_real(g11), .g22_real(g22), .g12_real(g12r), .g12_imag(g12i), .inv_det(inv),
        .bram_rd_addr(bram_rd_addr), .af_bram_rd_real(af_re), .af_bram_rd_imag(af_im),
        .result_bram_wr_en(wr_en), .bram_wr_addr(bram_wr_addr),
        .result_bram_wr_real(wr_re), .result_bram_wr_imag(wr_im),
        .busy(busy), .done(done), .err(err)
    );

    // Steering BRAM: {re, im}, two register stages of read latency
    logic [31:0] mem [0:8191];
    logic [31:0] d1 = '0, d2 = '0;
    always @(posedge clk) begin
        d1 <= mem[bram_rd_addr];
        d2 <= d1;
    end
    assign af_re = d2[31:16];
    assign af_im = d2[15:0];

    // Result BRAM capture; each bin run stamps its writes with a fresh tag
    logic [31:0] cap     [0:8191];
    int          cap_tag [0:8191];
    int          tag = 0;
    int          wr_cnt = 0, done_cnt = 0, err_cnt = 0, last_wr = 0;
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt                <= wr_cnt + 1;
            last_wr               <= int'(bram_wr_addr);
            cap[bram_wr_addr]     <= {wr_re, wr_im};
            cap_tag[bram_wr_addr] <= tag;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
    end

    typedef struct {
        logic [31:0] g11, g22, g12r, g12i, inv;
        int freq;
        int a0r_base, a0r_step, a0i, a1r, a1i;
        int w0r_base, w0r_step, w0i, w1r, w1i;
        int busy_start;
    } vec_t;

    vec_t vecs [6];
    int   n_vec = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_start(input int k);
        @(negedge clk);
        g11 = vecs[k].g11; g22 = vecs[k].g22; g12r = vecs[k].g12r;
        g12i = vecs[k].g12i; inv = vecs[k].inv; freq_idx = 9'(vecs[k].freq);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int base, cyc, done_cyc, w0, dc0, ec0;
        logic [31:0] exp_w;
        v = vecs[k];
        base = v.freq * 16;
        tag++;
        for (int m = 0; m < MIC; m++) begin
            mem[base + m]     = {16'(v.a0r_base + m * v.a0r_step), 16'(v.a0i)};
            mem[base + 8 + m] = {16'(v.a1r), 16'(v.a1i)};
        end
        w0 = wr_cnt; dc0 = done_cnt; ec0 = err_cnt;
        drive_start(k);
        cyc = 1;
        done_cyc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == 5) chk($sformatf("v%0d_busy_mid", k), 64'(busy), 64'd1);
            if (v.busy_start != 0 && cyc == v.busy_start) begin
                freq_idx = 9'd300; g11 = '0; g22 = '0; inv = '0;
                start = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            cyc++;
        end
        chk($sformatf("v%0d_done_cycle", k), 64'(done_cyc), 64'd50);
        repeat (3) @(negedge clk);
        #1;
        chk($sformatf("v%0d_wr_count", k), 64'(wr_cnt - w0), 64'd16);
        chk($sformatf("v%0d_done_count", k), 64'(done_cnt - dc0), 64'd1);
        chk($sformatf("v%0d_err_count", k), 64'(err_cnt - ec0), 64'd0);
        chk($sformatf("v%0d_busy_after", k), 64'(busy), 64'd0);
        chk($sformatf("v%0d_rd_addr_hold", k), 64'(bram_rd_addr), 64'(base + 15));
        chk($sformatf("v%0d_last_wr_addr", k), 64'(last_wr), 64'(base + 15));
        for (int m = 0; m < MIC; m++) begin
            exp_w = {16'(v.w0r_base + m * v.w0r_step), 16'(v.w0i)};
            chk($sformatf("v%0d_W0_m%0d", k, m),
                (cap_tag[base + m] == tag) ? 64'(cap[base + m]) : 64'hDEAD_0000_0000, 64'(exp_w));
            exp_w = {16'(v.w1r), 16'(v.w1i)};
            chk($sformatf("v%0d_W1_m%0d", k, m),
                (cap_tag[base + 8 + m] == tag) ? 64'(cap[base + 8 + m]) : 64'hDEAD_0000_0000, 64'(exp_w));
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bram_rd_addr, wr_en, bram_wr_addr, wr_re, wr_im, busy, done, err});
    endfunction

    initial begin
        int w0, dc0, ec0;
        logic [12:0] ra0;
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        //        g11           g22           g12r          g12i          inv           freq a0r  step  a0i   a1r    a1i  w0r    step  w0i    w1r    w1i  busy
        vecs[0] = '{32'h1000_0000, 32'h1000_0000, 32'h0, 32'h0, 32'h4000_0000, 3, 0, 1024, 0, 0, 512, 0, 1024, 0, 0, -512, 0};
        vecs[1] = '{32'h1000_0000, 32'h1000_0000, 32'h0800_0000, 32'h0, 32'h4000_0000, 5, 0, 0, 0, 16384, 0, -8192, 0, 0, 16384, 0, 10};
        vecs[2] = '{32'h2000_0000, 32'h2000_0000, 32'h0, 32'h0, 32'h7FFF_FFFF, 7, 16384, 0, 0, 0, 0, 32767, 0, 0, 0, 0, 0};
        vecs[3] = '{32'h1000_0000, 32'h0800_0000, 32'h0, 32'h0400_0000, 32'h4000_0000, 100, 4096, 0, 8192, -4096, 0, 2048, 0, -3072, -2048, 1024, 0};
        vecs[4] = '{32'h1000_0000, 32'h1000_0000, 32'h0, 32'h0, 32'h4000_0000, 256, 0, 1024, 0, 0, 512, 0, 1024, 0, 0, -512, 0};
        vecs[5] = '{32'h1000_0000, 32'h0800_0000, 32'h0, 32'h0, 32'h4000_0000, 1, 1, 0, -1, -3, 0, 1, 0, 1, -3, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_in_rst", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs_idle", all_outs(), 64'd0);

        for (int k = 0; k < 6; k++) run_vec(k);

        // Out-of-range bin index
        #1;
        ra0 = bram_rd_addr; w0 = wr_cnt; dc0 = done_cnt; ec0 = err_cnt;
        @(negedge clk);
        freq_idx = 9'd257;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("badidx_err_pulse", 64'(err), 64'd1);
        chk("badidx_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("badidx_err_one_cycle", 64'(err), 64'd0);
        repeat (60) @(negedge clk);
        #1;
        chk("badidx_err_count", 64'(err_cnt - ec0), 64'd1);
        chk("badidx_no_writes", 64'(wr_cnt - w0), 64'd0);
        chk("badidx_no_done", 64'(done_cnt - dc0), 64'd0);
        chk("badidx_rd_addr", 64'(bram_rd_addr), 64'(ra0));

        // Reset in the middle of a bin
        drive_start(0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_outputs_zero", all_outs(), 64'd0);
        #1;
        w0 = wr_cnt; dc0 = done_cnt;
        repeat (60) @(negedge clk);
        #1;
        chk("midrst_no_writes", 64'(wr_cnt - w0), 64'd0);
        chk("midrst_no_done", 64'(done_cnt - dc0), 64'd0);
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
